// File: rtl/risc_pkg.sv
// -----------------------------------------------------------------------------
// risc_pkg
// Definitions shared by the instruction fetch unit and its helpers:
//   - instruction field layout (opcode 31:26, rd 25:22, rs1 21:18,
//     imm16 17:2, imm26 25:0), expressed as overlapping packed views
//   - next-PC source select encodings
//   - fetch FSM state encoding
//   - sign-extension helper for the 16-bit immediate
// -----------------------------------------------------------------------------
package risc_pkg;

    // I-type view: register fields plus the 16-bit immediate in bits 17:2.
    typedef struct packed {
        logic [5:0]  opcode;   // 31:26
        logic [3:0]  rd;       // 25:22
        logic [3:0]  rs1;      // 21:18
        logic [15:0] imm16;    // 17:2
        logic [1:0]  lo;       // 1:0
    } instr_i_t;

    // J-type view: 26-bit absolute target in bits 25:0.
    typedef struct packed {
        logic [5:0]  opcode;   // 31:26
        logic [25:0] imm26;    // 25:0
    } instr_j_t;

    // Both views alias the same 32-bit word.
    typedef union packed {
        instr_i_t i;
        instr_j_t j;
    } instr_u;

    // Next-PC source select.
    typedef enum logic [1:0] {
        PcSelInc    = 2'b00,   // PC + 4
        PcSelBranch = 2'b01,   // pc_out + sext(imm16)
        PcSelJump   = 2'b10,   // {pc_out[31:26], imm26}
        PcSelExt    = 2'b11    // externally supplied target
    } pc_sel_e;

    // Fetch FSM states.
    typedef enum logic [1:0] {
        StFetch  = 2'b00,
        StHold   = 2'b01,
        StWaitPc = 2'b10,
        StFault  = 2'b11
    } fetch_state_e;

    function automatic logic [31:0] sext16(input logic [15:0] imm);
        return {{16{imm[15]}}, imm};
    endfunction

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// -----------------------------------------------------------------------------
// instruction_fetch_unit_if
// Bundles the instruction-memory port, the decode handshake and the PC
// control inputs of the fetch unit.
//   master : fetch unit side (drives imem_addr, ir_out, pc_out, ir_valid,
//            fault; samples imem_data, ir_ready, pc_update, pc_sel,
//            ext_target)
//   slave  : environment side (memory, decode and control)
// -----------------------------------------------------------------------------
interface instruction_fetch_unit_if;

    logic [31:0] imem_addr;    // byte address to instruction memory
    logic [31:0] imem_data;    // instruction word for imem_addr (combinational)
    logic [31:0] ir_out;       // latched instruction to decode
    logic [31:0] pc_out;       // address ir_out was fetched from
    logic        ir_valid;     // ir_out/pc_out hold an unconsumed instruction
    logic        ir_ready;     // decode accepts ir_out this cycle
    logic        pc_update;    // compute and load the next PC
    logic [1:0]  pc_sel;       // next-PC source select
    logic [31:0] ext_target;   // target used when pc_sel selects external
    logic        fault;        // sticky misaligned/out-of-range PC

    modport master (
        output imem_addr,
        output ir_out,
        output pc_out,
        output ir_valid,
        output fault,
        input  imem_data,
        input  ir_ready,
        input  pc_update,
        input  pc_sel,
        input  ext_target
    );

    modport slave (
        input  imem_addr,
        input  ir_out,
        input  pc_out,
        input  ir_valid,
        input  fault,
        output imem_data,
        output ir_ready,
        output pc_update,
        output pc_sel,
        output ext_target
    );

endinterface

// File: rtl/next_pc_calc.sv
// -----------------------------------------------------------------------------
// next_pc_calc
// Purely combinational next-PC computation and legality check.
// Ports:
//   i_pc         : current PC (equal to the fetched pc_out whenever the
//                  result is consumed)
//   i_ir         : latched instruction supplying branch/jump immediates
//   i_pc_sel     : next-PC source select
//   i_ext_target : external target
//   o_next_pc    : computed next PC (wraps modulo 2^32)
//   o_bad_pc     : next PC is misaligned or outside the instruction space
// -----------------------------------------------------------------------------
module next_pc_calc
    import risc_pkg::*;
#(
    parameter int unsigned IMEM_BYTES = 1024
) (
    input  logic [31:0] i_pc,
    input  logic [31:0] i_ir,
    input  pc_sel_e     i_pc_sel,
    input  logic [31:0] i_ext_target,
    output logic [31:0] o_next_pc,
    output logic        o_bad_pc
);

    instr_u      w_ir;
    logic        w_unused_ir;
    logic        w_misaligned;
    logic        w_out_of_range;

    assign w_ir = i_ir;

    // Opcode and the two low bits play no part in target generation.
    assign w_unused_ir = ^{w_ir.i.opcode, w_ir.i.lo};

    always_comb begin
        o_next_pc = i_pc + 32'd4;
        unique case (i_pc_sel)
            PcSelInc:    o_next_pc = i_pc + 32'd4;
            PcSelBranch: o_next_pc = i_pc + sext16(w_ir.i.imm16);
            PcSelJump:   o_next_pc = {i_pc[31:26], w_ir.j.imm26};
            PcSelExt:    o_next_pc = i_ext_target;
        endcase
    end

    assign w_misaligned   = (o_next_pc[1:0] != 2'b00);
    // 33-bit compare so an IMEM_BYTES of 2^32-1 cannot wrap.
    assign w_out_of_range = ({1'b0, o_next_pc} >= 33'(IMEM_BYTES));
    assign o_bad_pc       = w_misaligned || w_out_of_range;

endmodule

// File: rtl/instruction_fetch_unit.sv
// -----------------------------------------------------------------------------
// instruction_fetch_unit
// Single-clock fetch stage. Fetches one instruction per PC, presents it to
// decode with a valid/ready handshake, then waits for a control strobe to
// choose the next PC. An illegal next PC parks the unit in a sticky fault
// state that only reset clears.
// Ports:
//   i_clk   : clock, all state updates on its rising edge
//   i_reset : synchronous active-high reset
//   bus     : fetch-side modport carrying the memory port, decode handshake
//             and PC control signals
// Parameters:
//   IMEM_BYTES : byte size of the addressable instruction space
//   RESET_PC   : PC loaded on reset
// -----------------------------------------------------------------------------
module instruction_fetch_unit
    import risc_pkg::*;
#(
    parameter int unsigned IMEM_BYTES = 1024,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
    input  logic                            i_clk,
    input  logic                            i_reset,
    instruction_fetch_unit_if.master        bus
);

    fetch_state_e r_state;
    fetch_state_e w_state_next;

    logic [31:0]  r_pc;
    logic [31:0]  w_pc_next;
    logic [31:0]  r_ir;
    logic [31:0]  w_ir_next;
    logic [31:0]  r_pc_out;
    logic [31:0]  w_pc_out_next;
    logic         r_ir_valid;
    logic         w_ir_valid_next;
    logic         r_fault;
    logic         w_fault_next;

    logic [31:0]  w_calc_pc;
    logic         w_calc_bad;

    // r_pc only moves on a WAIT_PC update and every path into WAIT_PC passes
    // through FETCH, so r_pc equals r_pc_out whenever the result is used.
    next_pc_calc #(
        .IMEM_BYTES (IMEM_BYTES)
    ) u_next_pc_calc (
        .i_pc         (r_pc),
        .i_ir         (r_ir),
        .i_pc_sel     (pc_sel_e'(bus.pc_sel)),
        .i_ext_target (bus.ext_target),
        .o_next_pc    (w_calc_pc),
        .o_bad_pc     (w_calc_bad)
    );

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= StFetch;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Datapath registers.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_pc       <= RESET_PC;
            r_ir       <= 32'd0;
            r_pc_out   <= 32'd0;
            r_ir_valid <= 1'b0;
            r_fault    <= 1'b0;
        end else begin
            r_pc       <= w_pc_next;
            r_ir       <= w_ir_next;
            r_pc_out   <= w_pc_out_next;
            r_ir_valid <= w_ir_valid_next;
            r_fault    <= w_fault_next;
        end
    end

    // Next-state and datapath update.
    always_comb begin
        w_state_next    = r_state;
        w_pc_next       = r_pc;
        w_ir_next       = r_ir;
        w_pc_out_next   = r_pc_out;
        w_ir_valid_next = r_ir_valid;
        w_fault_next    = r_fault;

        unique case (r_state)
            StFetch: begin
                w_ir_next       = bus.imem_data;
                w_pc_out_next   = r_pc;
                w_ir_valid_next = 1'b1;
                w_state_next    = StHold;
            end
            StHold: begin
                // pc_update is deliberately not looked at here.
                if (bus.ir_ready) begin
                    w_ir_valid_next = 1'b0;
                    w_state_next    = StWaitPc;
                end
            end
            StWaitPc: begin
                if (bus.pc_update) begin
                    // An illegal target is still loaded so it can be inspected
                    // on imem_addr, but it is never fetched.
                    w_pc_next = w_calc_pc;
                    if (w_calc_bad) begin
                        w_fault_next = 1'b1;
                        w_state_next = StFault;
                    end else begin
                        w_state_next = StFetch;
                    end
                end
            end
            StFault: begin
                w_ir_valid_next = 1'b0;
                w_fault_next    = 1'b1;
            end
        endcase
    end

    assign bus.imem_addr = r_pc;
    assign bus.ir_out    = r_ir;
    assign bus.pc_out    = r_pc_out;
    assign bus.ir_valid  = r_ir_valid;
    assign bus.fault     = r_fault;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_instruction_fetch_unit
// Self-checking bench: a word-array memory model answers imem_addr, a queue
// holds the {pc, instruction} each fetch must deliver, and a monitor pops it
// on every rising ir_valid. A table of next-PC vectors walks the PC through
// increment, branch, jump and external targets; hand sequences cover fetch
// latency, backpressure, reset in HOLD and fault entry/exit.
// -----------------------------------------------------------------------------
module tb_instruction_fetch_unit;

    localparam int unsigned IMEM = 1024;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    instruction_fetch_unit_if bus ();

    instruction_fetch_unit #(
        .IMEM_BYTES (IMEM),
        .RESET_PC   (32'h0000_0000)
    ) dut (
        .i_clk   (clk),
        .i_reset (reset),
        .bus     (bus)
    );

    logic [31:0] mem [256];

    assign bus.imem_data = (bus.imem_addr < 32'(IMEM)) ? mem[bus.imem_addr[9:2]]
                                                       : 32'hDEAD_BEEF;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ir;
    } fetch_t;

    typedef struct {
        string       name;
        logic [1:0]  sel;
        logic [31:0] ext;
        logic [31:0] exp_pc;
        logic        exp_fault;
    } vec_t;

    fetch_t sb_q[$];
    vec_t   vecs[13];
    int     n_tests = 0;
    int     n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Each rising ir_valid must match the oldest expected fetch.
    initial begin : monitor
        logic   prev_valid;
        fetch_t e;
        prev_valid = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.ir_valid === 1'b1 && prev_valid !== 1'b1) begin
                if (sb_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_fetch: pc_out %h, expected no fetch", bus.pc_out);
                end else begin
                    e = sb_q.pop_front();
                    check("fetch_pc_out", bus.pc_out, e.pc);
                    check("fetch_ir_out", bus.ir_out, e.ir);
                end
            end
            prev_valid = bus.ir_valid;
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic push_fetch(input logic [31:0] pc);
        fetch_t f;
        f.pc = pc;
        f.ir = mem[pc[9:2]];
        sb_q.push_back(f);
    endtask

    task automatic wait_valid(input string name);
        int k;
        k = 0;
        while (bus.ir_valid !== 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
        end
        check({name, "_valid"}, {31'd0, bus.ir_valid}, 32'd1);
    endtask

    // Apply reset for one edge, check reset values, then release and expect
    // the fetch from address 0 to complete at the very next edge.
    task automatic reset_and_start(input string name);
        reset         = 1'b1;
        bus.ir_ready  = 1'b0;
        bus.pc_update = 1'b0;
        @(negedge clk);
        check({name, "_rst_valid"}, {31'd0, bus.ir_valid}, 32'd0);
        check({name, "_rst_fault"}, {31'd0, bus.fault}, 32'd0);
        check({name, "_rst_addr"}, bus.imem_addr, 32'd0);
        check({name, "_rst_ir"}, bus.ir_out, 32'd0);
        check({name, "_rst_pc_out"}, bus.pc_out, 32'd0);
        push_fetch(32'd0);
        reset = 1'b0;
        @(negedge clk);
        check({name, "_first_valid"}, {31'd0, bus.ir_valid}, 32'd1);
    endtask

    // From HOLD: accept the instruction, strobe pc_update, check the new PC.
    task automatic step(input string name, input logic [1:0] sel, input logic [31:0] ext,
                        input logic [31:0] exp_pc, input logic exp_fault);
        bus.ir_ready = 1'b1;
        @(negedge clk);
        bus.ir_ready   = 1'b0;
        bus.pc_update  = 1'b1;
        bus.pc_sel     = sel;
        bus.ext_target = ext;
        if (!exp_fault) push_fetch(exp_pc);
        @(negedge clk);
        bus.pc_update = 1'b0;
        check({name, "_addr"}, bus.imem_addr, exp_pc);
        check({name, "_fault"}, {31'd0, bus.fault}, {31'd0, exp_fault});
        if (!exp_fault) begin
            wait_valid(name);
        end else begin
            for (int c = 0; c < 2; c++) begin
                @(negedge clk);
                check({name, "_flt_valid"}, {31'd0, bus.ir_valid}, 32'd0);
            end
        end
    endtask

    initial begin : stim
        int cnt;

        for (int i = 0; i < 256; i++) mem[i] = 32'hA500_0000 | 32'(i);
        mem[0]  = 32'h0C00_0000;
        mem[4]  = 32'h0400_0030;   // imm16 = 12
        mem[10] = 32'h0803_FF80;   // imm16 = 16'hFFE0 (-32)
        mem[11] = 32'h0800_002C;   // imm26 = 44

        vecs[0]  = '{"inc_0_4",      2'b00, 32'd0,    32'd4,    1'b0};
        vecs[1]  = '{"inc_4_8",      2'b00, 32'd0,    32'd8,    1'b0};
        vecs[2]  = '{"ext_16",       2'b11, 32'd16,   32'd16,   1'b0};
        vecs[3]  = '{"branch_pos",   2'b01, 32'd0,    32'd28,   1'b0};
        vecs[4]  = '{"ext_40",       2'b11, 32'd40,   32'd40,   1'b0};
        vecs[5]  = '{"branch_neg",   2'b01, 32'd0,    32'd8,    1'b0};
        vecs[6]  = '{"ext_44",       2'b11, 32'd44,   32'd44,   1'b0};
        vecs[7]  = '{"jump_loop_a",  2'b10, 32'd0,    32'd44,   1'b0};
        vecs[8]  = '{"jump_loop_b",  2'b10, 32'd0,    32'd44,   1'b0};
        vecs[9]  = '{"jump_loop_c",  2'b10, 32'd0,    32'd44,   1'b0};
        vecs[10] = '{"inc_48",       2'b00, 32'd0,    32'd48,   1'b0};
        vecs[11] = '{"ext_top_word", 2'b11, 32'd1020, 32'd1020, 1'b0};
        vecs[12] = '{"inc_past_end", 2'b00, 32'd0,    32'd1024, 1'b1};

        bus.ir_ready   = 1'b0;
        bus.pc_update  = 1'b0;
        bus.pc_sel     = 2'b00;
        bus.ext_target = 32'd0;
        reset          = 1'b1;

        // Sequential fetch with ready/update held high: 3-cycle fetch spacing.
        reset_and_start("seq");
        bus.ir_ready  = 1'b1;
        bus.pc_update = 1'b1;
        bus.pc_sel    = 2'b00;
        push_fetch(32'd4);
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (!(bus.ir_valid === 1'b1 && bus.pc_out === 32'd4) && cnt < 10);
        bus.ir_ready  = 1'b0;
        bus.pc_update = 1'b0;
        check("seq_latency", 32'(cnt), 32'd3);

        // Backpressure in HOLD with pc_update pulsing.
        bus.pc_sel     = 2'b11;
        bus.ext_target = 32'h100;
        for (int c = 0; c < 5; c++) begin
            bus.pc_update = (c % 2 == 0);
            @(negedge clk);
            check("bp_valid", {31'd0, bus.ir_valid}, 32'd1);
            check("bp_pc_out", bus.pc_out, 32'd4);
            check("bp_ir_out", bus.ir_out, mem[1]);
            check("bp_addr", bus.imem_addr, 32'd4);
        end
        // pc_update coinciding with ir_ready in HOLD is dropped.
        bus.ir_ready  = 1'b1;
        bus.pc_update = 1'b1;
        @(negedge clk);
        bus.ir_ready  = 1'b0;
        bus.pc_update = 1'b0;
        for (int c = 0; c < 3; c++) begin
            check("coinc_valid", {31'd0, bus.ir_valid}, 32'd0);
            check("coinc_addr", bus.imem_addr, 32'd4);
            @(negedge clk);
        end
        bus.pc_update = 1'b1;
        bus.pc_sel    = 2'b00;
        push_fetch(32'd8);
        @(negedge clk);
        bus.pc_update = 1'b0;
        wait_valid("resume");

        // Reset while an unaccepted instruction is held.
        reset_and_start("hold_rst");

        // Next-PC table walk, ending in an out-of-range fault.
        for (int i = 0; i < 13; i++) begin
            step(vecs[i].name, vecs[i].sel, vecs[i].ext, vecs[i].exp_pc, vecs[i].exp_fault);
        end

        // FAULT ignores all handshake and control inputs.
        bus.ir_ready  = 1'b1;
        bus.pc_update = 1'b1;
        bus.pc_sel    = 2'b00;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("fault_sticky", {31'd0, bus.fault}, 32'd1);
            check("fault_no_valid", {31'd0, bus.ir_valid}, 32'd0);
            check("fault_addr_kept", bus.imem_addr, 32'd1024);
        end

        reset_and_start("fault_exit_a");
        step("misaligned_6", 2'b11, 32'h0000_0006, 32'h0000_0006, 1'b1);
        reset_and_start("fault_exit_b");
        step("ext_1024", 2'b11, 32'd1024, 32'd1024, 1'b1);
        reset_and_start("fault_exit_c");
        step("after_fault_inc", 2'b00, 32'd0, 32'd4, 1'b0);

        repeat (2) @(negedge clk);
        check("scoreboard_empty", 32'(sb_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
